// File: rtl/shift_reg.sv
// Universal shift register: parallel load, clear, logical/arithmetic shifts
// and rotates. Multi-position shifts run one position per clock under a
// start/busy/done handshake; sin/sout allow chaining instances.
module shift_reg #(
    parameter int               WIDTH     = 8,
    parameter int               AMT_W     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] in,
    input  logic             sin,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_LOAD  = 3'b000;
    localparam logic [2:0] MODE_SHL   = 3'b001;
    localparam logic [2:0] MODE_SHR   = 3'b010;
    localparam logic [2:0] MODE_ASR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
    localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       cmd_mode;
    logic [AMT_W-1:0] cnt;
    logic             dir;      // 0: bits leave from the MSB end, 1: from the LSB end

    // One single-position step of the given shift/rotate kind.
    function automatic logic [WIDTH-1:0] step_once(
        input logic [WIDTH-1:0] v,
        input logic [2:0]       m,
        input logic             s
    );
        logic [WIDTH-1:0] r;
        case (m)
            MODE_SHL: r = {v[WIDTH-2:0], s};
            MODE_SHR: r = {s, v[WIDTH-1:1]};
            MODE_ASR: r = {v[WIDTH-1], v[WIDTH-1:1]};
            MODE_ROL: r = {v[WIDTH-2:0], v[WIDTH-1]};
            MODE_ROR: r = {v[0], v[WIDTH-1:1]};
            default:  r = v;
        endcase
        return r;
    endfunction

    // The bit that the next step would push out, on the side set by dir.
    assign sout = dir ? out[0] : out[WIDTH-1];

    // Command acceptance, per-step execution and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            out      <= RESET_VAL;
            cmd_mode <= 3'b111;
            cnt      <= CNT_ZERO;
            dir      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_mode <= mode;
                        cnt      <= amt;
                        case (mode)
                            MODE_LOAD: begin
                                out  <= in;
                                done <= 1'b1;
                            end
                            MODE_CLEAR: begin
                                out  <= RESET_VAL;
                                done <= 1'b1;
                            end
                            MODE_SHL, MODE_SHR, MODE_ASR, MODE_ROL, MODE_ROR: begin
                                dir <= (mode == MODE_SHR) || (mode == MODE_ASR) ||
                                       (mode == MODE_ROR);
                                if (amt == CNT_ZERO) begin
                                    done <= 1'b1;
                                end else begin
                                    state <= RUN;
                                    busy  <= 1'b1;
                                end
                            end
                            default: begin
                                // NOP: contents untouched, still a completed command
                                done <= 1'b1;
                            end
                        endcase
                    end
                end
                RUN: begin
                    // start is ignored here; the latched cmd_mode drives the step
                    out <= step_once(out, cmd_mode, sin);
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench for shift_reg (WIDTH=8, AMT_W=4): directed scenarios
// followed by randomized commands, compared against an arithmetic model.
module tb_shift_reg;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] mode;
    logic [3:0] amt;
    logic [7:0] in;
    logic       sin;
    logic [7:0] out;
    logic       sout;
    logic       busy;
    logic       done;

    int vectors = 0;
    int errors  = 0;

    // model state: register value and which end sout looks at
    logic [7:0] m_out;
    bit         m_lsb_side;

    shift_reg #(.WIDTH(8), .AMT_W(4), .RESET_VAL(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .in    (in),
        .sin   (sin),
        .out   (out),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One position of movement, computed with integer arithmetic on 0..255.
    function automatic logic [7:0] ref_step(input logic [7:0] v, input logic [2:0] m, input logic s);
        int x;
        int r;
        x = int'(v);
        case (m)
            3'd1:    r = (x * 2) % 256 + int'(s);
            3'd2:    r = x / 2 + int'(s) * 128;
            3'd3:    r = x / 2 + ((x >= 128) ? 128 : 0);
            3'd4:    r = (x * 2) % 256 + x / 128;
            3'd5:    r = x / 2 + (x % 2) * 128;
            default: r = x;
        endcase
        return r[7:0];
    endfunction

    function automatic logic exp_sout();
        return m_lsb_side ? m_out[0] : m_out[7];
    endfunction

    function automatic logic pick_sin(input int sel);
        if (sel == 2) return 1'($urandom_range(0, 1));
        return sel[0];
    endfunction

    // Issue one command and check every cycle until its done pulse.
    // abuse: 0 quiet inputs during RUN, 1 pulse LOAD 0x00, 2 random garbage.
    task automatic run_cmd(input logic [2:0] md, input int n, input logic [7:0] din,
                           input int sin_sel, input int abuse);
        logic s;
        bit   single;
        start = 1'b1;
        mode  = md;
        amt   = 4'(n);
        in    = din;
        sin   = pick_sin(sin_sel);
        tick();
        start = 1'b0;
        if (md == 3'd0) m_out = din;
        if (md == 3'd6) m_out = 8'h00;
        if (md >= 3'd1 && md <= 3'd5) m_lsb_side = (md == 3'd2 || md == 3'd3 || md == 3'd5);
        single = (md == 3'd0) || (md >= 3'd6) || (n == 0);
        if (single) begin
            check("single_out", out, m_out);
            check("single_done", done, 1'b1);
            check("single_busy", busy, 1'b0);
            check("single_sout", sout, exp_sout());
            return;
        end
        check("e0_out", out, m_out);
        check("e0_busy", busy, 1'b1);
        check("e0_done", done, 1'b0);
        for (int k = 1; k <= n; k++) begin
            sin = pick_sin(sin_sel);
            if (abuse == 1) begin
                start = (k == 2);
                mode  = 3'd0;
                in    = 8'h00;
            end else if (abuse == 2) begin
                start = 1'($urandom_range(0, 1));
                mode  = 3'($urandom_range(0, 7));
                amt   = 4'($urandom_range(0, 15));
                in    = 8'($urandom);
            end
            s = sin;
            tick();
            m_out = ref_step(m_out, md, s);
            check("step_out", out, m_out);
            check("step_sout", sout, exp_sout());
            check("step_busy", busy, (k < n) ? 1'b1 : 1'b0);
            check("step_done", done, (k == n) ? 1'b1 : 1'b0);
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 3'd7;
        amt   = 4'd0;
        in    = 8'h00;
        sin   = 1'b0;
        m_out = 8'h00;
        m_lsb_side = 1'b0;
        #3;
        check("rst_out", out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sout", sout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("idle_done", done, 1'b0);

        // asynchronous reset right after a LOAD, while done is high
        run_cmd(3'd0, 0, 8'h5A, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", out, 8'h00);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_sout", sout, 1'b0);
        m_out = 8'h00;
        m_lsb_side = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // LOAD then zero-amount shift
        run_cmd(3'd0, 0, 8'hA5, 2, 0);
        run_cmd(3'd1, 0, 8'h00, 2, 0);
        check("shl0_const", out, 8'hA5);

        // rotate out and back
        run_cmd(3'd4, 3, 8'h00, 2, 0);
        check("rol3_const", out, 8'h2D);
        run_cmd(3'd5, 3, 8'h00, 2, 0);
        check("ror3_const", out, 8'hA5);

        // arithmetic shift and serial fill
        run_cmd(3'd0, 0, 8'h96, 0, 0);
        run_cmd(3'd3, 2, 8'h00, 2, 0);
        check("asr2_const", out, 8'hE5);
        run_cmd(3'd0, 0, 8'h00, 0, 0);
        run_cmd(3'd1, 8, 8'h00, 1, 0);
        check("shl8_const", out, 8'hFF);
        run_cmd(3'd2, 12, 8'h00, 0, 0);
        check("shr_flush", out, 8'h00);
        run_cmd(3'd0, 0, 8'h80, 0, 0);
        run_cmd(3'd3, 11, 8'h00, 0, 0);
        check("asr_sat", out, 8'hFF);

        // start during RUN is ignored
        run_cmd(3'd0, 0, 8'hA5, 0, 0);
        run_cmd(3'd4, 5, 8'h00, 0, 1);
        check("rol5_const", out, 8'hB4);
        tick();
        check("done_single", done, 1'b0);

        // reset in the middle of a rotate
        start = 1'b1;
        mode  = 3'd4;
        amt   = 4'd5;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", out, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_sout", sout, 1'b0);
        m_out = 8'h00;
        m_lsb_side = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_done", done, 1'b0);
            check("post_rst_busy", busy, 1'b0);
            check("post_rst_out", out, 8'h00);
        end

        // back-to-back accept in the done cycle, then wrap-around rotate
        run_cmd(3'd0, 0, 8'h3C, 2, 0);
        run_cmd(3'd4, 2, 8'h00, 2, 0);
        run_cmd(3'd0, 0, 8'h81, 2, 0);
        check("b2b_load", out, 8'h81);
        run_cmd(3'd4, 9, 8'h00, 2, 0);
        check("rol9_const", out, 8'h03);

        // randomized commands with garbage inputs during RUN
        for (int i = 0; i < 40; i++) begin
            run_cmd(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                    8'($urandom), 2, 2);
        end
        tick();
        check("final_done", done, 1'b0);
        check("final_busy", busy, 1'b0);
        check("final_out", out, m_out);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
